// File: rtl/uart_tx_if.sv
// Host-side handshake and serial-line bundle for the UART transmitter.
// The transmitter takes the slave modport; host logic (or a bench) takes master.
interface uart_tx_if #(
  parameter int data_bits_p = 8
);
  logic                   tx_v_i;
  logic [data_bits_p-1:0] tx_i;
  logic                   tx_ready_and_o;
  logic                   tx_o;
  logic                   tx_done_o;

  modport slave (
    input  tx_v_i,
    input  tx_i,
    output tx_ready_and_o,
    output tx_o,
    output tx_done_o
  );

  modport master (
    output tx_v_i,
    output tx_i,
    input  tx_ready_and_o,
    input  tx_o,
    input  tx_done_o
  );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: one word per valid/ready handshake is sent as
// start bit, LSB-first data, optional parity bit and one or two stop bits.
module uart_tx #(
  parameter int clk_per_bit_p = 10416,
  parameter int data_bits_p   = 8,
  parameter int parity_bit_p  = 0,
  parameter int parity_odd_p  = 0,
  parameter int stop_bits_p   = 1
) (
  input  logic     clk_i,
  input  logic     reset_n_i,
  uart_tx_if.slave bus
);

  localparam int cnt_w_lp = $clog2(clk_per_bit_p + 1);
  localparam int idx_w_lp = $clog2(data_bits_p + 1);

  localparam logic [cnt_w_lp-1:0] cnt_last_lp  = cnt_w_lp'(clk_per_bit_p - 1);
  localparam logic [idx_w_lp-1:0] data_last_lp = idx_w_lp'(data_bits_p - 1);
  localparam logic [idx_w_lp-1:0] stop_last_lp = idx_w_lp'(stop_bits_p - 1);

  typedef enum logic [2:0] {
    e_reset      = 3'd0,
    e_idle       = 3'd1,
    e_start_bit  = 3'd2,
    e_data_bits  = 3'd3,
    e_parity_bit = 3'd4,
    e_stop_bit   = 3'd5
  } state_e;

  state_e                 state_q,  state_d;
  logic [cnt_w_lp-1:0]    cnt_q,    cnt_d;
  logic [idx_w_lp-1:0]    idx_q,    idx_d;
  logic [data_bits_p-1:0] shift_q,  shift_d;
  logic                   parity_q, parity_d;
  logic                   tx_q,     tx_d;
  logic                   done_q,   done_d;
  logic                   bit_end;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q  <= e_reset;
      cnt_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      parity_q <= 1'b0;
      tx_q     <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      parity_q <= parity_d;
      tx_q     <= tx_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    parity_d = parity_q;
    done_d   = 1'b0;
    bit_end  = (cnt_q == cnt_last_lp);

    case (state_q)
      e_reset: begin
        state_d = e_idle;
      end

      e_idle: begin
        cnt_d = '0;
        idx_d = '0;
        if (bus.tx_v_i) begin
          shift_d  = bus.tx_i;
          parity_d = (^bus.tx_i) ^ (parity_odd_p != 0);
          state_d  = e_start_bit;
        end
      end

      e_start_bit: begin
        cnt_d = bit_end ? '0 : cnt_q + 1'b1;
        if (bit_end) begin
          state_d = e_data_bits;
        end
      end

      e_data_bits: begin
        cnt_d = bit_end ? '0 : cnt_q + 1'b1;
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (idx_q == data_last_lp) begin
            idx_d   = '0;
            state_d = (parity_bit_p != 0) ? e_parity_bit : e_stop_bit;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end

      e_parity_bit: begin
        cnt_d = bit_end ? '0 : cnt_q + 1'b1;
        if (bit_end) begin
          state_d = e_stop_bit;
        end
      end

      // The bit index doubles as the stop-bit counter.
      e_stop_bit: begin
        cnt_d = bit_end ? '0 : cnt_q + 1'b1;
        if (bit_end) begin
          if (idx_q == stop_last_lp) begin
            idx_d   = '0;
            done_d  = 1'b1;
            state_d = e_idle;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = e_reset;
      end
    endcase

    // Line level follows the state being entered so tx_o is a plain flop.
    case (state_d)
      e_start_bit:  tx_d = 1'b0;
      e_data_bits:  tx_d = shift_d[0];
      e_parity_bit: tx_d = parity_d;
      default:      tx_d = 1'b1;
    endcase
  end

  assign bus.tx_ready_and_o = (state_q == e_idle);
  assign bus.tx_o           = tx_q;
  assign bus.tx_done_o      = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: five configurations, a frame-level model
// per instance checked every cycle, plus hand-computed frame expectations.
module tb_uart_tx;

  localparam int NI = 5;

  // Instance configs: 0=8N1 1=8E1 2=8O1 3=7N2 (all 4 clk/bit), 4=5N1 at 2 clk/bit.
  function automatic int cfg_p(input int i);
    return (i == 4) ? 2 : 4;
  endfunction
  function automatic int cfg_d(input int i);
    return (i == 3) ? 7 : ((i == 4) ? 5 : 8);
  endfunction
  function automatic int cfg_par(input int i);
    return (i == 1 || i == 2) ? 1 : 0;
  endfunction
  function automatic int cfg_odd(input int i);
    return (i == 2) ? 1 : 0;
  endfunction
  function automatic int cfg_s(input int i);
    return (i == 3) ? 2 : 1;
  endfunction

  typedef struct packed {
    logic line;
    logic done;
    logic ready;
  } exp_t;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b1;
  logic [NI-1:0] tx_v  = '0;
  logic [8:0]    tx_data [NI];
  logic [NI-1:0] tx_line;
  logic [NI-1:0] tx_ready;
  logic [NI-1:0] tx_done;

  int checks = 0;
  int errors = 0;

  logic rec_line  [256];
  logic rec_done  [256];
  logic rec_ready [256];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    localparam int P   = cfg_p(gi);
    localparam int D   = cfg_d(gi);
    localparam int PAR = cfg_par(gi);
    localparam int ODD = cfg_odd(gi);
    localparam int S   = cfg_s(gi);

    uart_tx_if #(.data_bits_p(D)) bus ();

    assign bus.tx_v_i   = tx_v[gi];
    assign bus.tx_i     = tx_data[gi][D-1:0];
    assign tx_line[gi]  = bus.tx_o;
    assign tx_ready[gi] = bus.tx_ready_and_o;
    assign tx_done[gi]  = bus.tx_done_o;

    uart_tx #(
      .clk_per_bit_p(P),
      .data_bits_p  (D),
      .parity_bit_p (PAR),
      .parity_odd_p (ODD),
      .stop_bits_p  (S)
    ) u_dut (
      .clk_i    (clk),
      .reset_n_i(rst_n),
      .bus      (bus)
    );

    // Frame model: on an accepted word, queue the whole expected line waveform.
    exp_t exp_q[$];
    int   boot = 1;

    always @(negedge clk) begin : model
      exp_t       e;
      exp_t       ent;
      logic [8:0] w;
      logic       par;
      logic       bv;
      if (!rst_n) begin
        exp_q.delete();
        boot = 1;
        e = '{line: 1'b1, done: 1'b0, ready: 1'b0};
      end else if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
      end else if (boot > 0) begin
        e = '{line: 1'b1, done: 1'b0, ready: 1'b0};
        boot--;
      end else begin
        e = '{line: 1'b1, done: 1'b0, ready: 1'b1};
      end

      checks++;
      if (tx_line[gi] !== e.line || tx_ready[gi] !== e.ready || tx_done[gi] !== e.done) begin
        errors++;
        $display("FAIL model_cmp inst%0d t=%0t line/ready/done got %b%b%b expected %b%b%b",
                 gi, $time, tx_line[gi], tx_ready[gi], tx_done[gi], e.line, e.ready, e.done);
      end

      if (rst_n && e.ready && tx_v[gi]) begin
        w   = tx_data[gi] & 9'((1 << D) - 1);
        par = (^w) ^ (ODD != 0);
        for (int b = 0; b < 1 + D + PAR + S; b++) begin
          if (b == 0)                    bv = 1'b0;
          else if (b <= D)               bv = w[b-1];
          else if (PAR != 0 && b == D+1) bv = par;
          else                           bv = 1'b1;
          ent.line  = bv;
          ent.done  = 1'b0;
          ent.ready = 1'b0;
          for (int c = 0; c < P; c++) exp_q.push_back(ent);
        end
        ent.line  = 1'b1;
        ent.done  = 1'b1;
        ent.ready = 1'b1;
        exp_q.push_back(ent);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic record(input int idx, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      rec_line[k]  = tx_line[idx];
      rec_done[k]  = tx_done[idx];
      rec_ready[k] = tx_ready[idx];
    end
  endtask

  task automatic wait_ready(input int idx);
    int n = 0;
    @(posedge clk);
    #1;
    while (!tx_ready[idx] && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk($sformatf("ready_wait%0d", idx), 32'(tx_ready[idx]), 32'd1);
  endtask

  // Offer one word; rec[0] is the idle cycle before the accepting edge.
  task automatic send_rec(input int idx, input logic [8:0] data, input int n);
    wait_ready(idx);
    tx_v[idx]    = 1'b1;
    tx_data[idx] = data;
    fork
      record(idx, n);
      begin
        @(posedge clk);
        #1;
        tx_v[idx]    = 1'b0;
        tx_data[idx] = ~data;
      end
    join
  endtask

  task automatic check_bits(input string name, input int base, input int p, input int nb,
                            input logic [15:0] exp);
    logic [15:0] got = '0;
    for (int b = 0; b < nb; b++) got[b] = rec_line[base + b*p + p/2];
    chk(name, 32'(got), 32'(exp));
  endtask

  function automatic int first_done(input int n);
    for (int k = 0; k < n; k++) if (rec_done[k] === 1'b1) return k;
    return -1;
  endfunction

  function automatic int sum_done(input int lo, input int hi);
    int s = 0;
    for (int k = lo; k <= hi; k++) s += int'(rec_done[k]);
    return s;
  endfunction

  function automatic int sum_line(input int lo, input int hi);
    int s = 0;
    for (int k = lo; k <= hi; k++) s += int'(rec_line[k]);
    return s;
  endfunction

  function automatic int sum_ready(input int lo, input int hi);
    int s = 0;
    for (int k = lo; k <= hi; k++) s += int'(rec_ready[k]);
    return s;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int run;
    for (int i = 0; i < NI; i++) tx_data[i] = '0;

    #1 rst_n = 1'b0;
    #2;
    for (int i = 0; i < NI; i++)
      chk($sformatf("reset_state%0d", i), 32'({tx_line[i], tx_ready[i], tx_done[i]}), 32'b100);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("post_release_ready", 32'(tx_ready[0]), 32'd0);

    // 8N1 0xA5
    send_rec(0, 9'h0A5, 48);
    $display("t1 8N1 0xA5 done_at=%0d", first_done(48));
    check_bits("t1_bits", 1, 4, 10, 16'h034A);
    chk("t1_done_at", 32'(first_done(48)), 32'd41);
    chk("t1_done_cnt", 32'(sum_done(0, 47)), 32'd1);
    chk("t1_ready_low", 32'(sum_ready(1, 40)), 32'd0);

    // Parity: 8E1 0x07, 8O1 0x07, 8E1 0x00
    send_rec(1, 9'h007, 50);
    $display("t2 8E1 0x07 parity=%b", rec_line[39]);
    chk("t2_even_07", 32'(rec_line[39]), 32'd1);
    check_bits("t2_even_07_bits", 1, 4, 11, 16'h060E);
    chk("t2_even_done_at", 32'(first_done(50)), 32'd45);
    send_rec(2, 9'h007, 50);
    $display("t2 8O1 0x07 parity=%b", rec_line[39]);
    chk("t2_odd_07", 32'(rec_line[39]), 32'd0);
    send_rec(1, 9'h000, 50);
    $display("t2 8E1 0x00 parity=%b", rec_line[39]);
    chk("t2_even_00", 32'(rec_line[39]), 32'd0);

    // 7N2 0x7F
    send_rec(3, 9'h07F, 48);
    $display("t3 7N2 0x7F done_at=%0d", first_done(48));
    check_bits("t3_bits", 1, 4, 10, 16'h03FE);
    chk("t3_done_at", 32'(first_done(48)), 32'd41);
    chk("t3_stop_high", 32'(sum_line(33, 40)), 32'd8);

    // Back-to-back with tx_v held: 0x55 then 0xAA, data disturbed mid-frame
    wait_ready(0);
    tx_v[0]    = 1'b1;
    tx_data[0] = 9'h055;
    fork
      record(0, 90);
      begin
        @(posedge clk);
        @(posedge clk);
        #1 tx_data[0] = 9'h0AA;
        repeat (41) @(posedge clk);
        #1;
        tx_data[0] = 9'h00F;
        tx_v[0]    = 1'b0;
      end
    join
    run = 0;
    for (int k = 41; k > 0 && rec_line[k] === 1'b1; k--) run++;
    $display("t4 back-to-back high_run=%0d done_cnt=%0d", run, sum_done(0, 89));
    check_bits("t4_frame1", 1, 4, 10, 16'h02AA);
    check_bits("t4_frame2", 42, 4, 10, 16'h0354);
    chk("t4_high_run", 32'(run), 32'd5);
    chk("t4_done_cnt", 32'(sum_done(0, 89)), 32'd2);
    chk("t4_done2_at", 32'(rec_done[82]), 32'd1);

    // Reset during data bit 3 of 0xF0
    wait_ready(0);
    tx_v[0]    = 1'b1;
    tx_data[0] = 9'h0F0;
    fork
      record(0, 18);
      begin
        @(posedge clk);
        #1 tx_v[0] = 1'b0;
      end
    join
    chk("t5_line_was_low", 32'(rec_line[17]), 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    $display("t5 reset mid-frame line=%b", tx_line[0]);
    chk("t5_line_high_now", 32'(tx_line[0]), 32'd1);
    chk("t5_no_done_before", 32'(sum_done(0, 17)), 32'd0);
    record(0, 3);
    chk("t5_no_done_in_reset", 32'(sum_done(0, 2)), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    chk("t5_ready_low_release", 32'(tx_ready[0]), 32'd0);
    n = 0;
    while (!tx_ready[0] && n < 5) begin
      @(negedge clk);
      n++;
    end
    $display("t5 ready latency=%0d", n);
    chk("t5_ready_latency", 32'(n), 32'd2);
    send_rec(0, 9'h03C, 48);
    $display("t5 8N1 0x3C after reset done_at=%0d", first_done(48));
    check_bits("t5_bits_3c", 1, 4, 10, 16'h0278);
    chk("t5_done_at", 32'(first_done(48)), 32'd41);

    // 5N1 at 2 clk/bit, 0x1F
    send_rec(4, 9'h01F, 20);
    $display("t6 5N1 0x1F done_at=%0d", first_done(20));
    check_bits("t6_bits", 1, 2, 7, 16'h007E);
    chk("t6_done_at", 32'(first_done(20)), 32'd15);
    chk("t6_done_cnt", 32'(sum_done(0, 19)), 32'd1);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
